ml_frame_decoder: RTL and testbench

Receive-side framing stage of the ML model harness. Consumes the byte stream from the SPI peripheral's receive output (`o_RX_DV`/`o_RX_Byte`), validates framed commands, stores the payload, and presents a complete frame to the model loader over a valid/ready handshake. Malformed frames and aborted transfers are discarded, and an error pulse with a cause code is raised for each.

---
 rtl/ml_frame_pkg.sv | 23 ++
 rtl/ml_frame_buffer.sv | 45 ++++
 rtl/ml_frame_decoder.sv | 147 ++++++++++++++
 tb/tb_ml_frame_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ml_frame_pkg.sv
// ml_frame_pkg
//   Shared definitions for the ML harness receive framing stage:
//   decoder state encoding, error cause codes and the default
//   start-of-frame byte.
package ml_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_HOLD = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_CHK   = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/ml_frame_buffer.sv
// ml_frame_buffer
//   MAX_LEN x 8 payload store: one write port, one registered read port.
//   Reads at or beyond the current frame length (rlen) return 8'h00.
//   Ports:
//     clk, rst_n         clock, async active-low reset (read register only)
//     we, waddr, wdata   write strobe, address, data
//     raddr, rlen        read address, current frame length
//     rdata              registered read data
module ml_frame_buffer #(
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  input  logic [7:0] rlen,
  output logic [7:0] rdata
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX8 = 8'(MAX_LEN);

  logic [7:0] mem [MAX_LEN];

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we && (waddr < MAX8)) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  // The MAX8 guard keeps a non power-of-two depth from indexing past the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 8'h00;
    end else if ((raddr < rlen) && (raddr < MAX8)) begin
      rdata <= mem[raddr[AW-1:0]];
    end else begin
      rdata <= 8'h00;
    end
  end

endmodule

// File: rtl/ml_frame_decoder.sv
// ml_frame_decoder
//   Receive framing stage: parses SOF, CMD, LEN, payload, CHK from the SPI
//   byte stream, checks CHK = XOR(CMD, LEN, payload) and holds the frame
//   for the model loader.
//   Handshake: o_frame_valid stays high from the cycle after the CHK byte
//   until the cycle after an edge that samples o_frame_valid && i_frame_ready;
//   o_cmd, o_len and the payload are stable for that whole interval.
//   Ports:
//     clk, i_Rst_L                 clock, async active-low reset
//     i_rx_dv, i_rx_byte, i_cs_n   byte strobe/data, synchronised chip select
//     o_frame_valid, i_frame_ready frame handshake
//     o_cmd, o_len                 held frame header
//     i_rd_addr, o_rd_data         payload read port (1-cycle latency)
//     o_err, o_err_code            error pulse and cause
//     o_overrun                    byte dropped while a frame was held
//     o_busy                       decoder not idle
module ml_frame_decoder
  import ml_frame_pkg::*;
#(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = SOF_DEFAULT
) (
  input  logic       clk,
  input  logic       i_Rst_L,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  input  logic       i_cs_n,
  output logic       o_frame_valid,
  input  logic       i_frame_ready,
  output logic [7:0] o_cmd,
  output logic [7:0] o_len,
  input  logic [7:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam logic [7:0] MAX8 = 8'(MAX_LEN);

  state_t     state;
  logic [7:0] xor_q;
  logic [7:0] widx;
  logic [7:0] widx_nxt;
  logic       in_frame;
  logic       abort;
  logic       buf_we;

  // Chip select only matters between SOF and the checksum byte.
  assign in_frame = (state == ST_CMD) || (state == ST_LEN) ||
                    (state == ST_DATA) || (state == ST_CHK);
  assign abort    = in_frame && i_cs_n;
  assign widx_nxt = widx + 8'd1;
  assign buf_we   = (state == ST_DATA) && i_rx_dv && !abort;

  assign o_frame_valid = (state == ST_HOLD);
  assign o_busy        = (state != ST_IDLE);

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state      <= ST_IDLE;
      xor_q      <= 8'h00;
      widx       <= 8'h00;
      o_cmd      <= 8'h00;
      o_len      <= 8'h00;
      o_err      <= 1'b0;
      o_err_code <= ERR_NONE;
      o_overrun  <= 1'b0;
    end else begin
      o_err      <= 1'b0;
      o_err_code <= ERR_NONE;
      o_overrun  <= 1'b0;
      if (abort) begin
        // Abort beats a byte arriving in the same cycle.
        o_err      <= 1'b1;
        o_err_code <= ERR_ABORT;
        state      <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_rx_dv && (i_rx_byte == SOF)) state <= ST_CMD;
          end
          ST_CMD: begin
            if (i_rx_dv) begin
              o_cmd <= i_rx_byte;
              xor_q <= i_rx_byte;
              state <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (i_rx_dv) begin
              if ((i_rx_byte == 8'h00) || (i_rx_byte > MAX8)) begin
                o_err      <= 1'b1;
                o_err_code <= ERR_LEN;
                state      <= ST_IDLE;
              end else begin
                o_len <= i_rx_byte;
                xor_q <= xor_q ^ i_rx_byte;
                widx  <= 8'h00;
                state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (i_rx_dv) begin
              xor_q <= xor_q ^ i_rx_byte;
              widx  <= widx_nxt;
              if (widx_nxt == o_len) state <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (i_rx_dv) begin
              if (i_rx_byte == xor_q) begin
                state <= ST_HOLD;
              end else begin
                o_err      <= 1'b1;
                o_err_code <= ERR_CHK;
                state      <= ST_IDLE;
              end
            end
          end
          ST_HOLD: begin
            // Bytes are never accepted here, even on the handshake edge.
            if (i_rx_dv) o_overrun <= 1'b1;
            if (i_frame_ready) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  ml_frame_buffer #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .clk   (clk),
    .rst_n (i_Rst_L),
    .we    (buf_we),
    .waddr (widx),
    .wdata (i_rx_byte),
    .raddr (i_rd_addr),
    .rlen  (o_len),
    .rdata (o_rd_data)
  );

endmodule

// File: tb/tb_ml_frame_decoder.sv
// tb_ml_frame_decoder
//   Directed bench for ml_frame_decoder (MAX_LEN=16, SOF=A5).
//   Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_ml_frame_decoder;

  logic       clk;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       cs_n;
  logic       frame_valid;
  logic       frame_ready;
  logic [7:0] cmd;
  logic [7:0] len;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       err;
  logic [1:0] err_code;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ml_frame_decoder #(
    .MAX_LEN (16),
    .SOF     (8'hA5)
  ) dut (
    .clk           (clk),
    .i_Rst_L       (rst_n),
    .i_rx_dv       (rx_dv),
    .i_rx_byte     (rx_byte),
    .i_cs_n        (cs_n),
    .o_frame_valid (frame_valid),
    .i_frame_ready (frame_ready),
    .o_cmd         (cmd),
    .o_len         (len),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_err         (err),
    .o_err_code    (err_code),
    .o_overrun     (overrun),
    .o_busy        (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; consecutive calls give back-to-back bytes.
  task automatic send(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic read_at(input logic [7:0] a);
    rd_addr = a;
    tick();
  endtask

  // comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    rx_dv       = 1'b0;
    rx_byte     = 8'h00;
    cs_n        = 1'b0;
    frame_ready = 1'b0;
    rd_addr     = 8'h00;

    // reset state
    repeat (3) tick();
    chk("rst_valid", 32'(frame_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_code", 32'(err_code), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_len", 32'(len), 32'h0);
    chk("rst_rd", 32'(rd_data), 32'h0);
    rst_n = 1'b1;
    tick();

    // good frame: CHK = 10^03^11^22^33 = 13
    send(8'h5A);
    chk("idle_junk_busy", 32'(busy), 32'h0);
    send(8'hA5);
    chk("sof_busy", 32'(busy), 32'h1);
    send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    chk("pre_chk_valid", 32'(frame_valid), 32'h0);
    send(8'h13);
    chk("good_valid", 32'(frame_valid), 32'h1);
    chk("good_cmd", 32'(cmd), 32'h10);
    chk("good_len", 32'(len), 32'h03);
    chk("good_err", 32'(err), 32'h0);
    read_at(8'd0); chk("rd0", 32'(rd_data), 32'h11);
    read_at(8'd1); chk("rd1", 32'(rd_data), 32'h22);
    read_at(8'd2); chk("rd2", 32'(rd_data), 32'h33);
    read_at(8'd3); chk("rd3_oor", 32'(rd_data), 32'h00);

    // overrun while held
    send(8'h77);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_valid", 32'(frame_valid), 32'h1);
    send(8'hA5);
    chk("ovr_pulse2", 32'(overrun), 32'h1);
    tick();
    chk("ovr_one_cycle", 32'(overrun), 32'h0);
    chk("ovr_cmd", 32'(cmd), 32'h10);
    chk("ovr_len", 32'(len), 32'h03);
    read_at(8'd0); chk("ovr_rd0", 32'(rd_data), 32'h11);
    read_at(8'd2); chk("ovr_rd2", 32'(rd_data), 32'h33);

    // handshake with a simultaneous SOF byte: byte dropped, overrun pulses
    frame_ready = 1'b1;
    send(8'hA5);
    frame_ready = 1'b0;
    chk("hs_valid_fall", 32'(frame_valid), 32'h0);
    chk("hs_overrun", 32'(overrun), 32'h1);
    chk("hs_busy", 32'(busy), 32'h0);

    // bad checksum, then an immediately following good frame
    send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    send(8'h04);
    chk("badchk_err", 32'(err), 32'h1);
    chk("badchk_code", 32'(err_code), 32'h2);
    chk("badchk_valid", 32'(frame_valid), 32'h0);
    chk("badchk_busy", 32'(busy), 32'h0);
    send(8'hA5);
    chk("badchk_err_fall", 32'(err), 32'h0);
    chk("badchk_code_fall", 32'(err_code), 32'h0);
    send(8'h10); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h13);
    chk("after_bad_valid", 32'(frame_valid), 32'h1);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("after_bad_release", 32'(frame_valid), 32'h0);
    // SOF accepted on the cycle the frame is released
    send(8'hA5);
    chk("sof_after_release", 32'(busy), 32'h1);
    cs_n = 1'b1;
    tick();
    cs_n = 1'b0;
    chk("abort_cmd_code", 32'(err_code), 32'h3);

    // LEN = 0
    send(8'hA5); send(8'h20); send(8'h00);
    chk("len0_err", 32'(err), 32'h1);
    chk("len0_code", 32'(err_code), 32'h1);
    send(8'h11);
    chk("len0_discard", 32'(busy), 32'h0);
    chk("len0_err_fall", 32'(err), 32'h0);

    // LEN = MAX_LEN + 1
    send(8'hA5); send(8'h20); send(8'h11);
    chk("len17_err", 32'(err), 32'h1);
    chk("len17_code", 32'(err_code), 32'h1);
    send(8'h22); send(8'h33);
    chk("len17_discard", 32'(busy), 32'h0);

    // abort after the second payload byte
    send(8'hA5); send(8'h10); send(8'h03); send(8'h11); send(8'h22);
    chk("pre_abort_busy", 32'(busy), 32'h1);
    cs_n = 1'b1;
    tick();
    cs_n = 1'b0;
    chk("abort_err", 32'(err), 32'h1);
    chk("abort_code", 32'(err_code), 32'h3);
    chk("abort_busy", 32'(busy), 32'h0);
    tick();
    chk("abort_err_fall", 32'(err), 32'h0);

    // abort and byte in the same cycle: byte dropped
    send(8'hA5);
    cs_n = 1'b1;
    send(8'h10);
    cs_n = 1'b0;
    chk("abort_dv_code", 32'(err_code), 32'h3);
    chk("abort_dv_busy", 32'(busy), 32'h0);

    // maximum length frame: payload 00..0F, CHK = 20^10^(00^..^0F) = 30
    send(8'hA5); send(8'h20); send(8'h10);
    for (int i = 0; i < 16; i++) send(8'(i));
    send(8'h30);
    chk("max_valid", 32'(frame_valid), 32'h1);
    chk("max_len", 32'(len), 32'h10);
    read_at(8'd15); chk("max_rd15", 32'(rd_data), 32'h0F);
    read_at(8'd7);  chk("max_rd7", 32'(rd_data), 32'h07);
    read_at(8'd16); chk("max_rd16_oor", 32'(rd_data), 32'h00);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("max_release", 32'(frame_valid), 32'h0);

    // reset mid-DATA
    send(8'hA5); send(8'h10); send(8'h03); send(8'h11);
    rd_addr = 8'd0;
    rst_n = 1'b0;
    tick();
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_err", 32'(err), 32'h0);
    chk("mrst_cmd", 32'(cmd), 32'h0);
    chk("mrst_len", 32'(len), 32'h0);
    chk("mrst_rd", 32'(rd_data), 32'h0);
    chk("mrst_valid", 32'(frame_valid), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("mrst_no_err", 32'(err), 32'h0);

    // frame after reset: CHK = 42^02^AA^55 = BF
    send(8'hA5); send(8'h42); send(8'h02); send(8'hAA); send(8'h55); send(8'hBF);
    chk("post_valid", 32'(frame_valid), 32'h1);
    chk("post_cmd", 32'(cmd), 32'h42);
    chk("post_len", 32'(len), 32'h02);
    read_at(8'd0); chk("post_rd0", 32'(rd_data), 32'hAA);
    read_at(8'd1); chk("post_rd1", 32'(rd_data), 32'h55);
    read_at(8'd2); chk("post_rd2_oor", 32'(rd_data), 32'h00);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("post_release", 32'(frame_valid), 32'h0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
